dtw_dep_router: RTL

- Parametrised dependency-forwarding stage for the DTW systolic datapath.
- Keeps a DEPTH-deep history of the per-PE accumulated-distance vector coming out of the PE array.
- Routes N_OP operand vectors back to the PEs. Each operand lane independently chooses a history age and a source lane, or a ZERO / INF constant.
- Adds validity tracking, stall, synchronous flush and a saturating miss counter.

---
 rtl/dtw_pkg.sv | 30 +++
 rtl/dtw_lane_mux.sv | 59 +++++
 rtl/dtw_dep_router.sv | 85 ++++++++
 3 files changed

// File: rtl/dtw_pkg.sv
// Shared constants and helpers for the DTW systolic datapath.
// Packed vectors place element 0 (channel 0, lane 0) at the MSBs.
package dtw_pkg;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] dtw_inf(input int unsigned dw);
    return {MAX_W{1'b1}} >> (MAX_W - dw);
  endfunction

  // Lane-select code meaning "constant zero"
  function automatic logic [MAX_W-1:0] sel_zero(input int unsigned sw);
    return dtw_inf(sw);
  endfunction

  function automatic int unsigned sel_w(input int unsigned n_pe);
    return $clog2(n_pe + 2);
  endfunction

  function automatic int unsigned age_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned idx,
                                           input int unsigned n_elem,
                                           input int unsigned w);
    return (n_elem - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/dtw_lane_mux.sv
// One operand lane: picks a word from the live vector or a history
// snapshot, or a ZERO/INF constant, and flags reads of invalid data.
module dtw_lane_mux
  import dtw_pkg::*;
#(
  parameter int unsigned N_PE  = 6,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SW    = sel_w(N_PE),
  parameter int unsigned AW    = age_w(DEPTH)
) (
  input  logic [N_PE*DW-1:0]       d,
  input  logic [DEPTH*N_PE*DW-1:0] hist,
  input  logic [DEPTH-1:0]         hist_vld,
  input  logic                     d_vld,
  input  logic [SW-1:0]            sel,
  input  logic [AW-1:0]            age,
  output logic [DW-1:0]            word,
  output logic                     miss
);

  localparam logic [DW-1:0] INF       = DW'(dtw_inf(DW));
  localparam logic [SW-1:0] ZERO_CODE = SW'(sel_zero(SW));

  logic [DW-1:0] src;
  logic          src_vld;

  // An age beyond DEPTH matches nothing, leaving src_vld low -> INF + miss
  always_comb begin
    src     = '0;
    src_vld = 1'b0;
    for (int unsigned p = 0; p < N_PE; p++) begin
      if (sel == SW'(p)) begin
        if (age == '0) begin
          src     = d[elem_lsb(p, N_PE, DW) +: DW];
          src_vld = d_vld;
        end
        for (int unsigned k = 1; k <= DEPTH; k++) begin
          if (age == AW'(k)) begin
            src     = hist[elem_lsb((k - 1) * N_PE + p, DEPTH * N_PE, DW) +: DW];
            src_vld = hist_vld[k - 1];
          end
        end
      end
    end
  end

  always_comb begin
    word = INF;
    miss = 1'b0;
    if (sel == ZERO_CODE) begin
      word = '0;
    end else if (sel < SW'(N_PE)) begin
      if (src_vld) word = src;
      else         miss = 1'b1;
    end
  end

endmodule

// File: rtl/dtw_dep_router.sv
// Dependency-forwarding stage: DEPTH-deep history of the PE distance
// vector, per-lane operand routing, validity tracking and miss counting.
module dtw_dep_router
  import dtw_pkg::*;
#(
  parameter int unsigned N_PE  = 6,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned N_OP  = 3,
  parameter int unsigned SW    = sel_w(N_PE),
  parameter int unsigned AW    = age_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    ena,
  input  logic                    i_clr,
  input  logic [N_PE*DW-1:0]      i_d,
  input  logic                    i_d_vld,
  input  logic [N_OP*N_PE*SW-1:0] i_sel,
  input  logic [N_OP*N_PE*AW-1:0] i_age,
  output logic [N_OP*N_PE*DW-1:0] o_d,
  output logic [DEPTH-1:0]        o_hist_vld,
  output logic                    o_miss,
  output logic [15:0]             o_miss_cnt
);

  localparam int unsigned NL = N_OP * N_PE;

  logic [N_PE*DW-1:0]       h [DEPTH];  // h[k] holds age k+1
  logic [DEPTH-1:0]         v;
  logic [DEPTH*N_PE*DW-1:0] hist_flat;
  logic [NL-1:0]            lane_miss;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < DEPTH; k++) h[k] <= '0;
      v          <= '0;
      o_miss_cnt <= '0;
    end else if (i_clr) begin
      for (int unsigned k = 0; k < DEPTH; k++) h[k] <= '0;
      v          <= '0;
      o_miss_cnt <= '0;
    end else if (ena) begin
      h[0] <= i_d;
      v[0] <= i_d_vld;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        h[k] <= h[k - 1];
        v[k] <= v[k - 1];
      end
      if (o_miss && (o_miss_cnt != '1)) o_miss_cnt <= o_miss_cnt + 16'd1;
    end
  end

  always_comb begin
    hist_flat = '0;
    for (int unsigned k = 0; k < DEPTH; k++)
      hist_flat[elem_lsb(k, DEPTH, N_PE * DW) +: N_PE * DW] = h[k];
  end

  assign o_hist_vld = v;
  assign o_miss     = |lane_miss;

  for (genvar c = 0; c < N_OP; c++) begin : g_ch
    for (genvar p = 0; p < N_PE; p++) begin : g_lane
      localparam int unsigned IDX = c * N_PE + p;
      dtw_lane_mux #(
        .N_PE  (N_PE),
        .DW    (DW),
        .DEPTH (DEPTH),
        .SW    (SW),
        .AW    (AW)
      ) u_mux (
        .d        (i_d),
        .hist     (hist_flat),
        .hist_vld (v),
        .d_vld    (i_d_vld),
        .sel      (i_sel[elem_lsb(IDX, NL, SW) +: SW]),
        .age      (i_age[elem_lsb(IDX, NL, AW) +: AW]),
        .word     (o_d[elem_lsb(IDX, NL, DW) +: DW]),
        .miss     (lane_miss[IDX])
      );
    end
  end

endmodule
